// File: rtl/board_io_cond.sv
// Board input conditioning: per-channel synchronizer, debouncer, edge pulses,
// sticky pending flags with interrupt, plus a registered LED output bus.
module board_io_cond #(
  parameter int N_IN            = 21,
  parameter int N_OUT           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_IN-1:0]  i_raw,
  output logic [N_IN-1:0]  o_data,
  output logic [N_IN-1:0]  o_rise,
  output logic [N_IN-1:0]  o_fall,
  input  logic [N_IN-1:0]  i_rise_en,
  input  logic [N_IN-1:0]  i_fall_en,
  input  logic [N_IN-1:0]  i_clr,
  output logic [N_IN-1:0]  o_pending,
  output logic             o_irq,
  input  logic [N_OUT-1:0] i_gpio_out,
  output logic [N_OUT-1:0] o_led
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][N_IN-1:0] sync_q, sync_d;
  logic [N_IN-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [N_IN-1:0] sync;
  logic [N_IN-1:0] upd;
  logic [N_IN-1:0] stable_q, stable_d;
  logic [N_IN-1:0] rise_q, rise_d;
  logic [N_IN-1:0] fall_q, fall_d;
  logic [N_IN-1:0] pend_q, pend_d;
  logic [N_OUT-1:0] led_q, led_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_raw};
    led_d  = i_gpio_out;
  end

  // A channel flips only after sync has disagreed for DEBOUNCE_CYCLES edges
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    upd      = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (sync[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        upd[i]      = 1'b1;
        stable_d[i] = sync[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    rise_d = upd & stable_d;
    fall_d = upd & ~stable_d;
    pend_d = (rise_d & i_rise_en)
           | (fall_d & i_fall_en)
           | (pend_q & ~i_clr);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      pend_q   <= '0;
      led_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pend_q   <= pend_d;
      led_q    <= led_d;
    end
  end

  assign o_data    = stable_q;
  assign o_rise    = rise_q;
  assign o_fall    = fall_q;
  assign o_pending = pend_q;
  assign o_irq     = |pend_q;
  assign o_led     = led_q;

endmodule

// File: tb/tb_board_io_cond.sv
// Bench for board_io_cond: directed vector table, corner sequences,
// and random stimulus against a window-based reference model.
module tb_board_io_cond;

  localparam int N_IN  = 21;
  localparam int N_OUT = 16;
  localparam int SYNC  = 2;
  localparam int DC    = 4;
  localparam int HL    = SYNC + DC;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic [N_IN-1:0]  i_raw;
  logic [N_IN-1:0]  o_data, o_rise, o_fall;
  logic [N_IN-1:0]  i_rise_en, i_fall_en, i_clr;
  logic [N_IN-1:0]  o_pending;
  logic             o_irq;
  logic [N_OUT-1:0] i_gpio_out;
  logic [N_OUT-1:0] o_led;

  board_io_cond #(
    .N_IN(N_IN), .N_OUT(N_OUT),
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_raw(i_raw),
    .o_data(o_data), .o_rise(o_rise), .o_fall(o_fall),
    .i_rise_en(i_rise_en), .i_fall_en(i_fall_en), .i_clr(i_clr),
    .o_pending(o_pending), .o_irq(o_irq),
    .i_gpio_out(i_gpio_out), .o_led(o_led)
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [N_IN-1:0]  h [HL];
  logic [N_IN-1:0]  m_data, m_rise, m_fall, m_pend;
  logic [N_OUT-1:0] m_led;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
  endtask

  // sync seen at an edge = raw sampled SYNC edges earlier; a level is
  // accepted once the last DC sync values all differ from the held level
  task automatic model_edge(input logic rst, input logic [N_IN-1:0] raw,
                            input logic [N_IN-1:0] ren, fen, clr,
                            input logic [N_OUT-1:0] gpio);
    logic [N_IN-1:0] flip;
    logic diff;
    if (rst) begin
      for (int k = 0; k < HL; k++) h[k] = '0;
      m_data = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_led = '0;
    end else begin
      flip = '0;
      for (int b = 0; b < N_IN; b++) begin
        diff = 1'b1;
        for (int k = 0; k < DC; k++)
          if (h[SYNC-1+k][b] == m_data[b]) diff = 1'b0;
        flip[b] = diff;
      end
      m_rise = flip & ~m_data;
      m_fall = flip & m_data;
      m_data = m_data ^ flip;
      m_pend = (m_rise & ren) | (m_fall & fen) | (m_pend & ~clr);
      m_led  = gpio;
      for (int k = HL - 1; k > 0; k--) h[k] = h[k-1];
      h[0] = raw;
    end
  endtask

  task automatic step(input logic rst, input logic [N_IN-1:0] raw,
                      input logic [N_IN-1:0] ren, fen, clr,
                      input logic [N_OUT-1:0] gpio);
    i_reset = rst; i_raw = raw; i_rise_en = ren;
    i_fall_en = fen; i_clr = clr; i_gpio_out = gpio;
    @(posedge i_clk);
    model_edge(rst, raw, ren, fen, clr, gpio);
    #1;
    chk("model", {o_data, o_rise, o_fall, o_pending, o_irq, o_led},
                 {m_data, m_rise, m_fall, m_pend, |m_pend, m_led});
    chk("rise_fall_excl", 128'(o_rise & o_fall), 128'(0));
  endtask

  typedef struct {
    logic rst, raw, ren, fen, clr;
    logic [15:0] gpio;
    logic d, r, f, p, irq;
    logic [15:0] led;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, raw, ren, fen, clr,
                              logic [15:0] gpio, logic d, r, f, p, irq,
                              logic [15:0] led);
    vec_t v;
    v.rst = rst; v.raw = raw; v.ren = ren; v.fen = fen; v.clr = clr;
    v.gpio = gpio; v.d = d; v.r = r; v.f = f; v.p = p; v.irq = irq;
    v.led = led;
    return v;
  endfunction

  localparam logic [N_IN-1:0] ALL = '1;
  localparam logic [N_IN-1:0] NONE = '0;

  initial begin
    logic [N_IN-1:0] raw, msk, ren, fen, clr;
    logic rst;
    i_reset = 1'b1; i_raw = '0; i_rise_en = '0; i_fall_en = '0;
    i_clr = '0; i_gpio_out = '0;
    for (int k = 0; k < HL; k++) h[k] = '0;
    m_data = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_led = '0;

    // channel 0 rise, pending clear, fall, clear colliding with rise
    tbl.push_back(mk(1,0,0,0,0,16'hA5C3, 0,0,0,0,0,16'h0000));
    tbl.push_back(mk(0,0,1,0,0,16'hA5C3, 0,0,0,0,0,16'hA5C3));
    for (int k = 3; k <= 7; k++)
      tbl.push_back(mk(0,1,1,0,0,16'h1234, 0,0,0,0,0,16'h1234));
    tbl.push_back(mk(0,1,1,0,0,16'h1234, 1,1,0,1,1,16'h1234));
    tbl.push_back(mk(0,1,1,0,0,16'h1234, 1,0,0,1,1,16'h1234));
    tbl.push_back(mk(0,1,1,0,1,16'h1234, 1,0,0,0,0,16'h1234));
    tbl.push_back(mk(0,1,1,0,0,16'h1234, 1,0,0,0,0,16'h1234));
    for (int k = 12; k <= 16; k++)
      tbl.push_back(mk(0,0,1,0,0,16'h1234, 1,0,0,0,0,16'h1234));
    tbl.push_back(mk(0,0,1,0,0,16'h1234, 0,0,1,0,0,16'h1234));
    for (int k = 18; k <= 22; k++)
      tbl.push_back(mk(0,1,1,0,0,16'h1234, 0,0,0,0,0,16'h1234));
    tbl.push_back(mk(0,1,1,0,1,16'h1234, 1,1,0,1,1,16'h1234));
    tbl.push_back(mk(0,1,1,0,0,16'h1234, 1,0,0,1,1,16'h1234));

    foreach (tbl[i]) begin
      step(tbl[i].rst, N_IN'(tbl[i].raw), N_IN'(tbl[i].ren),
           N_IN'(tbl[i].fen), N_IN'(tbl[i].clr), tbl[i].gpio);
      chk($sformatf("tbl_row%0d", i),
          {o_data[0], o_rise[0], o_fall[0], o_pending[0], o_irq, o_led},
          {tbl[i].d, tbl[i].r, tbl[i].f, tbl[i].p, tbl[i].irq, tbl[i].led});
    end

    // 3-clock glitch on channel 3 must be ignored
    step(1, NONE, NONE, NONE, NONE, '0);
    for (int k = 0; k < 11; k++) begin
      raw = (k < 3) ? N_IN'(1 << 3) : NONE;
      step(0, raw, ALL, ALL, NONE, '0);
      chk("glitch_ch3", {o_data[3], o_rise[3], o_fall[3], o_pending[3]},
          4'b0000);
    end

    // channel 5 falling edge with only fall enabled
    step(1, NONE, NONE, NONE, NONE, '0);
    for (int k = 0; k < 8; k++)
      step(0, N_IN'(1 << 5), NONE, N_IN'(1 << 5), NONE, '0);
    chk("ch5_high", {o_data[5], o_pending[5]}, 2'b10);
    for (int k = 1; k <= 7; k++) begin
      step(0, NONE, NONE, N_IN'(1 << 5), NONE, '0);
      chk($sformatf("ch5_fall_e%0d", k),
          {o_fall[5], o_pending[5], o_data[5]},
          {k == 6, k >= 6, k < 6});
    end

    // reset mid-debounce restarts the full latency
    step(1, NONE, NONE, NONE, NONE, '0);
    for (int k = 1; k <= 3; k++) step(0, ALL, NONE, NONE, NONE, 16'hFFFF);
    step(1, ALL, NONE, NONE, NONE, 16'hFFFF);
    chk("reset_all_zero",
        {o_data, o_rise, o_fall, o_pending, o_irq, o_led}, 128'(0));
    for (int k = 1; k <= 8; k++) begin
      step(0, ALL, NONE, NONE, NONE, '0);
      chk($sformatf("post_reset_e%0d", k), {o_data, o_rise},
          {(k >= 6) ? ALL : NONE, (k == 6) ? ALL : NONE});
    end

    // random traffic with slowly toggling inputs
    raw = '0;
    for (int c = 0; c < 3000; c++) begin
      msk = '0;
      for (int b = 0; b < N_IN; b++)
        msk[b] = ($urandom_range(0, 5) == 0);
      raw = raw ^ msk;
      ren = N_IN'($urandom);
      fen = N_IN'($urandom);
      clr = N_IN'($urandom) & N_IN'($urandom) & N_IN'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      step(rst, raw, ren, fen, clr, N_OUT'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
